ula_seq: RTL and testbench
==========================

// Module: ula_seq
// PURPOSE
//  Parametrised sequential ALU, next generation of the 4-bit switch-driven ULA. Adds N-bit operands,
//  iterative multiply/divide (full-width product, quotient+remainder), status flags and start/done
//  handshake. Sits between the switch/operand registers and the seven-segment display path.
// PARAMETERS
//  W       4   operand/result width in bits (>=2)
//  CNT_W   $clog2(W+1)  iteration counter width (derived, not overridden)
// PORTS
//  CLOCK_50   in   1    system clock, all logic on rising edge
//  RESET_N    in   1    synchronous active-low reset
//  start      in   1    request; sampled only when busy=0
//  op         in   3    opcode, sampled with start
//  a          in   W    operand A, sampled with start
//  b          in   W    operand B, sampled with start
//  busy       out  1    1 while a MUL/DIV is iterating
//  done       out  1    one-cycle pulse: result/flags valid
//  result     out  W    low result / quotient
//  result_hi  out  W    MUL high half / DIV remainder; 0 for other ops
//  flags      out  4    {Z,C,V,DZ}: zero, carry/borrow, signed overflow, divide-by-zero
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, result=0, result_hi=0, flags=0, counter=0. Reset mid-operation
//    aborts the iteration; no done is produced for the aborted request.
//  - Opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB (a-b), 100 SHL1 (a*2), 101 SHR1 (a/2, logical),
//    110 MUL unsigned, 111 DIV unsigned.
//  - FSM: IDLE, CALC. IDLE & start & op<110 -> result registered, done=1 next cycle, stay IDLE (latency 1).
//    IDLE & start & op=MUL/DIV & !(DIV & b==0) -> CALC, busy=1 next cycle; W iterations (shift-add /
//    restoring divide), one bit per cycle; last iteration -> IDLE, busy=0, done=1. Start-to-done = W+1 cycles.
//  - DIV with b==0: single-cycle; result=all ones, result_hi=a, DZ=1, done after 1 cycle.
//  - start while busy=1: ignored, no queuing; operands/op held in internal registers during CALC,
//    so a/b/op may change freely after acceptance.
//  - start in the cycle done is high (state IDLE): accepted normally (back-to-back, 1 op/cycle for ALU ops).
//  - Width rules: ADD C = carry out of bit W-1; SUB C = borrow (a<b); SHL C = a[W-1]; SHR C = a[0];
//    V = signed overflow for ADD/SUB only, 0 otherwise; Z = (result==0) (low half only);
//    MUL/DIV C=V=0. Results wrap modulo 2^W.
//  - result/result_hi/flags hold their value until the next done; they change only in the done cycle.
//  - done is never asserted for two consecutive cycles for one request; busy and done never both 1.
// STRUCTURE
//  - Shared package ula_pkg: opcode localparams (OP_AND..OP_DIV), flag bit indices (F_Z,F_C,F_V,F_DZ),
//    state encoding (S_IDLE, S_CALC).
//  - One sub-module: ula_muldiv_iter (W-parameterised shift-add/restoring-divide datapath with
//    load/step/count-done); the top holds the FSM, single-cycle ops, flag logic and output registers.
//  - Display decoding stays in the existing seven-segment decoder, driven from result.
// TESTING (W=4 unless noted)
//  - AND/OR: a=1100,b=1010 op=000 -> result=1000,Z=0,done 1 cycle later; op=001 -> 1110.
//  - ADD/SUB: 9+8 -> result=0001,C=1,V=1; 3-5 -> result=1110,C=1,V=0; 5-5 -> 0000,Z=1.
//  - MUL: 15*15 -> busy 4 cycles, done at start+5, result_hi=1110,result=0001; start during busy ignored.
//  - DIV: 13/4 -> result=0011,result_hi=0001 at start+5; 7/0 -> result=1111,result_hi=0111,DZ=1 at start+1.
//  - Reset: RESET_N=0 during 3rd MUL iteration -> next cycle busy=0,done=0,outputs 0; no later done.
//  - Back-to-back: start held high with ADD then OR on consecutive cycles -> two consecutive done pulses;
//    W=8 regression: 200*3 -> result_hi=0x02,result=0x58 at start+9.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
package ula_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  // flags = {Z, C, V, DZ}
  localparam int F_Z  = 3;
  localparam int F_C  = 2;
  localparam int F_V  = 1;
  localparam int F_DZ = 0;

  typedef enum logic {S_IDLE = 1'b0, S_CALC = 1'b1} state_t;
endpackage

// File: rtl/ula_muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add unsigned multiply or restoring unsigned divide.
// hi/lo hold {product high, product low} or {remainder, quotient}; *_next is the post-step value.
module ula_muldiv_iter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     hi_reg, lo_reg, opnd_reg;
  logic             div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [W:0]       mul_add, mul_sum, shifted, diff;

  always_comb begin
    mul_add = lo_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}};
    mul_sum = {1'b0, hi_reg} + mul_add;
    shifted = {hi_reg, lo_reg[W-1]};
    diff    = shifted - {1'b0, opnd_reg};
    if (div_reg) begin
      // no borrow out of the trial subtraction means the divisor fits
      hi_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      lo_next = {lo_reg[W-2:0], ~diff[W]};
    end else begin
      hi_next = mul_sum[W:1];
      lo_next = {mul_sum[0], lo_reg[W-1:1]};
    end
    last = (cnt_reg == CNT_W'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      opnd_reg <= '0;
      div_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else if (load) begin
      hi_reg   <= '0;
      lo_reg   <= a;
      opnd_reg <= b;
      div_reg  <= div;
      cnt_reg  <= '0;
    end else if (step) begin
      hi_reg   <= hi_next;
      lo_reg   <= lo_next;
      cnt_reg  <= cnt_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ula_seq.sv
// Sequential ALU top: single-cycle logic/arith/shift ops, iterative MUL/DIV, flags and
// a start/done handshake with registered outputs.
module ula_seq
  import ula_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic [3:0]   flags
);
  state_t       state_reg;
  logic         busy_reg, done_reg;
  logic [W-1:0] result_reg, result_hi_reg;
  logic [3:0]   flags_reg;

  logic [W:0]   add_w, sub_w;
  logic [W-1:0] alu_res, hi_next, lo_next;
  logic         alu_c, alu_v, div_zero, is_iter, load, step, last;
  logic [3:0]   alu_flags;

  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = add_w[W-1:0];
        alu_c   = add_w[W];
        alu_v   = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[W-1:0];
        alu_c   = sub_w[W];
        alu_v   = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
      end
      OP_SHL: begin
        alu_res = {a[W-2:0], 1'b0};
        alu_c   = a[W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[W-1:1]};
        alu_c   = a[0];
      end
      default: ;
    endcase
    alu_flags        = '0;
    alu_flags[F_Z]   = (alu_res == '0);
    alu_flags[F_C]   = alu_c;
    alu_flags[F_V]   = alu_v;
    div_zero = (op == OP_DIV) && (b == '0);
    is_iter  = (op == OP_MUL) || (op == OP_DIV);
    load     = (state_reg == S_IDLE) && start && is_iter && !div_zero;
    step     = (state_reg == S_CALC);
  end

  ula_muldiv_iter #(.W(W)) u_iter (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .load    (load),
    .step    (step),
    .div     (op == OP_DIV),
    .a       (a),
    .b       (b),
    .last    (last),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (!is_iter) begin
              result_reg    <= alu_res;
              result_hi_reg <= '0;
              flags_reg     <= alu_flags;
              done_reg      <= 1'b1;
            end else if (div_zero) begin
              result_reg    <= '1;
              result_hi_reg <= a;
              flags_reg     <= 4'b0001;
              done_reg      <= 1'b1;
            end else begin
              state_reg <= S_CALC;
              busy_reg  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          // capture the post-step values on the final iteration
          if (last) begin
            state_reg        <= S_IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b1;
            result_reg       <= lo_next;
            result_hi_reg    <= hi_next;
            flags_reg        <= '0;
            flags_reg[F_Z]   <= (lo_next == '0);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign flags     = flags_reg;
endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq (W=4 instance plus a W=8 instance).
module tb_ula_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] a, b;
  logic       busy, done;
  logic [3:0] result, result_hi, flags;

  logic       start8;
  logic [2:0] op8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] result8, result_hi8;
  logic [3:0] flags8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_seq #(.W(4)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi), .flags(flags)
  );

  ula_seq #(.W(8)) dut8 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .result_hi(result_hi8), .flags(flags8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] r, input logic [3:0] rh,
                         input logic [3:0] f);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_res"}, {28'b0, result}, {28'b0, r});
    chk({tag, "_hi"}, {28'b0, result_hi}, {28'b0, rh});
    chk({tag, "_flags"}, {28'b0, flags}, {28'b0, f});
    $display("%s: result=%b result_hi=%b flags=%b", tag, result, result_hi, flags);
  endtask

  task automatic alu_op(input string tag, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [3:0] r, input logic [3:0] f);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    chk_out(tag, r, 4'b0000, f);
    tick();
    chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", {28'b0, result}, 32'd0);
    chk("rst_hi", {28'b0, result_hi}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    $display("reset: busy=%b done=%b result=%b", busy, done, result);
    rst_n = 1'b1;
    tick();

    alu_op("and", 3'b000, 4'b1100, 4'b1010, 4'b1000, 4'b0000);
    alu_op("or",  3'b001, 4'b1100, 4'b1010, 4'b1110, 4'b0000);
    alu_op("add_9_8", 3'b010, 4'd9, 4'd8, 4'b0001, 4'b0110);
    alu_op("sub_3_5", 3'b011, 4'd3, 4'd5, 4'b1110, 4'b0100);
    alu_op("sub_5_5", 3'b011, 4'd5, 4'd5, 4'b0000, 4'b1000);
    alu_op("shl_9", 3'b100, 4'b1001, 4'd0, 4'b0010, 4'b0100);
    alu_op("shr_1", 3'b101, 4'b0001, 4'd0, 4'b0000, 4'b1100);

    // MUL 15*15 with a competing start held high while busy
    start = 1'b1; op = 3'b110; a = 4'd15; b = 4'd15;
    tick();
    op = 3'b010; a = 4'd1; b = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("mul_busy_c%0d", i), {31'b0, busy}, 32'd1);
      chk($sformatf("mul_nodone_c%0d", i), {31'b0, done}, 32'd0);
      if (i == 4) start = 1'b0;
      if (i < 4) tick();
    end
    tick();
    chk_out("mul_15_15", 4'b0001, 4'b1110, 4'b0000);
    tick();
    chk("mul_pulse", {31'b0, done}, 32'd0);
    chk("mul_hold_res", {28'b0, result}, 32'd1);

    // DIV 13/4
    start = 1'b1; op = 3'b111; a = 4'd13; b = 4'd4;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("div_nodone_c4", {31'b0, done}, 32'd0);
    tick();
    chk_out("div_13_4", 4'b0011, 4'b0001, 4'b0000);

    alu_op_div0: begin
      start = 1'b1; op = 3'b111; a = 4'd7; b = 4'd0;
      tick();
      start = 1'b0;
      chk_out("div_7_0", 4'b1111, 4'b0111, 4'b0001);
      tick();
    end

    // reset during the third MUL iteration
    start = 1'b1; op = 3'b110; a = 4'd3; b = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_res", {28'b0, result}, 32'd0);
    chk("abort_hi", {28'b0, result_hi}, 32'd0);
    chk("abort_flags", {28'b0, flags}, 32'd0);
    $display("abort: busy=%b done=%b result=%b", busy, done, result);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", i), {31'b0, done}, 32'd0);
    end

    // back-to-back ADD then OR
    start = 1'b1; op = 3'b010; a = 4'd2; b = 4'd3;
    tick();
    op = 3'b001; a = 4'd4; b = 4'd2;
    chk_out("b2b_add", 4'b0101, 4'b0000, 4'b0000);
    tick();
    start = 1'b0;
    chk_out("b2b_or", 4'b0110, 4'b0000, 4'b0000);
    tick();
    chk("b2b_pulse", {31'b0, done}, 32'd0);

    // W=8: 200*3 = 600 = 0x258
    start8 = 1'b1; op8 = 3'b110; a8 = 8'd200; b8 = 8'd3;
    tick();
    start8 = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    chk("w8_busy_c8", {31'b0, busy8}, 32'd1);
    chk("w8_nodone_c8", {31'b0, done8}, 32'd0);
    tick();
    chk("w8_done", {31'b0, done8}, 32'd1);
    chk("w8_busy", {31'b0, busy8}, 32'd0);
    chk("w8_res", {24'b0, result8}, 32'h58);
    chk("w8_hi", {24'b0, result_hi8}, 32'h02);
    chk("w8_flags", {28'b0, flags8}, 32'd0);
    $display("w8_mul_200_3: result=%h result_hi=%h flags=%b", result8, result_hi8, flags8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
